// File: rtl/gelato_warp_issue_arbiter.sv
// ============================================================================
// gelato_warp_issue_arbiter
//
// Purpose:
//   Per-cycle warp issue scheduler that sits in front of the scoreboard.
//   - Each warp offers one decoded instruction candidate.
//   - Candidates with RAW/WAW hazards against their warp's dirty registers
//     are filtered out.
//   - One eligible warp is granted per cycle by round-robin.
//   - The granted instruction is held in a registered issue stage.
//   - When an instruction hands off downstream, its destination register
//     is reported so the scoreboard can mark it dirty.
//
// Optional feature (compile-time macro):
//   GELATO_ISSUE_WB_BYPASS_EN
//     When defined, a writeback in the current cycle masks that register
//     out of the hazard check, so a dependent warp can be granted in the
//     writeback cycle itself.
//     When undefined, a writeback only becomes visible through sb_regs on
//     the following cycle.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   rdy           global enable; low freezes all state, pulse outputs forced 0
//   cand_valid    per-warp candidate present
//   cand_rs1      per-warp source register 1 (0 = unused), packed by warp
//   cand_rs2      per-warp source register 2 (0 = unused), packed by warp
//   cand_rd       per-warp destination register (0 = none), packed by warp
//   cand_ready    one-hot pulse: candidate of that warp taken this cycle
//   sb_regs       scoreboard dirty registers, packed [warp][slot]
//   wb_valid      writeback strobe
//   wb_warp       writeback warp
//   wb_reg        writeback register
//   issue_valid   issue register holds an instruction
//   issue_ready   downstream accepts the held instruction
//   issue_warp    warp of the held instruction
//   issue_rs1     first source operand of the held instruction
//   issue_rs2     second source operand of the held instruction
//   issue_rd      destination operand of the held instruction
//   sb_new_reg    register to mark dirty this cycle (0 = nothing to record)
//   sb_warp_num   warp that sb_new_reg belongs to
//   stall_cycles  saturating count of cycles with candidates but no grant
// ============================================================================
module gelato_warp_issue_arbiter #(
    parameter int WARP_NUM = 4,
    parameter int SB_SIZE  = 4,
    parameter int REG_W    = 5,
    localparam int WIDX_W  = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rdy,
    input  logic [WARP_NUM-1:0]               cand_valid,
    input  logic [WARP_NUM*REG_W-1:0]         cand_rs1,
    input  logic [WARP_NUM*REG_W-1:0]         cand_rs2,
    input  logic [WARP_NUM*REG_W-1:0]         cand_rd,
    output logic [WARP_NUM-1:0]               cand_ready,
    input  logic [WARP_NUM*SB_SIZE*REG_W-1:0] sb_regs,
    input  logic                              wb_valid,
    input  logic [WIDX_W-1:0]                 wb_warp,
    input  logic [REG_W-1:0]                  wb_reg,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [WIDX_W-1:0]                 issue_warp,
    output logic [REG_W-1:0]                  issue_rs1,
    output logic [REG_W-1:0]                  issue_rs2,
    output logic [REG_W-1:0]                  issue_rd,
    output logic [REG_W-1:0]                  sb_new_reg,
    output logic [WIDX_W-1:0]                 sb_warp_num,
    output logic [31:0]                       stall_cycles
);

    typedef enum logic {
        ISSUE_EMPTY,
        ISSUE_FULL
    } issue_state_t;

    issue_state_t state_q;
    issue_state_t state_d;

    logic [WIDX_W-1:0]   rr_q;
    logic                shadow_valid_q;
    logic [WIDX_W-1:0]   shadow_warp_q;
    logic [REG_W-1:0]    shadow_reg_q;
    logic [WIDX_W-1:0]   issue_warp_q;
    logic [REG_W-1:0]    issue_rs1_q;
    logic [REG_W-1:0]    issue_rs2_q;
    logic [REG_W-1:0]    issue_rd_q;
    logic [31:0]         stall_q;

    logic [WARP_NUM-1:0] eligible;
    logic                grant_found;
    logic [WIDX_W-1:0]   grant_warp;
    logic                active;
    logic                handshake;
    logic                can_accept;
    logic                grant;

`ifndef GELATO_ISSUE_WB_BYPASS_EN
    // Writeback only reaches eligibility through sb_regs in this build.
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_warp, wb_reg};
`endif

    assign issue_valid  = (state_q == ISSUE_FULL);
    assign issue_warp   = issue_warp_q;
    assign issue_rs1    = issue_rs1_q;
    assign issue_rs2    = issue_rs2_q;
    assign issue_rd     = issue_rd_q;
    assign stall_cycles = stall_q;

    assign active     = rdy && !rst;
    assign handshake  = issue_valid && issue_ready;
    assign can_accept = !issue_valid || issue_ready;
    assign grant      = active && can_accept && grant_found;

    // Hazard filter.
    // A candidate is blocked when any of its nonzero registers matches a
    // dirty scoreboard slot of its own warp, or matches the shadow entry.
    // The shadow entry covers the one-cycle gap before the scoreboard
    // reflects the last recorded destination.
    // A candidate that writes a register also needs a free scoreboard slot.
    always_comb begin : eligibility
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] entry;
        logic             hazard;
        logic             row_full;
        logic             entry_dirty;
        rs1         = '0;
        rs2         = '0;
        rd          = '0;
        entry       = '0;
        hazard      = 1'b0;
        row_full    = 1'b0;
        entry_dirty = 1'b0;
        eligible    = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            rs1      = cand_rs1[w*REG_W +: REG_W];
            rs2      = cand_rs2[w*REG_W +: REG_W];
            rd       = cand_rd[w*REG_W +: REG_W];
            hazard   = 1'b0;
            row_full = 1'b1;
            for (int s = 0; s < SB_SIZE; s++) begin
                entry       = sb_regs[(w*SB_SIZE + s)*REG_W +: REG_W];
                entry_dirty = (entry != '0);
                if (entry == '0) begin
                    row_full = 1'b0;
                end
`ifdef GELATO_ISSUE_WB_BYPASS_EN
                if (wb_valid && (wb_warp == WIDX_W'(w)) && (entry == wb_reg)) begin
                    entry_dirty = 1'b0;
                end
`endif
                if (entry_dirty &&
                    (((rs1 != '0) && (rs1 == entry)) ||
                     ((rs2 != '0) && (rs2 == entry)) ||
                     ((rd  != '0) && (rd  == entry)))) begin
                    hazard = 1'b1;
                end
            end
            if (shadow_valid_q && (shadow_warp_q == WIDX_W'(w)) &&
                (((rs1 != '0) && (rs1 == shadow_reg_q)) ||
                 ((rs2 != '0) && (rs2 == shadow_reg_q)) ||
                 ((rd  != '0) && (rd  == shadow_reg_q)))) begin
                hazard = 1'b1;
            end
            eligible[w] = cand_valid[w] && !hazard && !((rd != '0) && row_full);
        end
    end

    // Round-robin pick.
    // Scans upward from the pointer with wrap and takes the first
    // eligible warp.
    always_comb begin : rr_pick
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_warp  = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            idx = (int'(rr_q) + i) % WARP_NUM;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_warp  = WIDX_W'(idx);
            end
        end
    end

    // Issue-stage next state and pulse outputs.
    // With rdy low or reset asserted, nothing moves and pulses stay low.
    // A full stage may accept a new grant in the same cycle it hands off,
    // which sustains one issue per cycle.
    always_comb begin : issue_fsm_comb
        state_d     = state_q;
        cand_ready  = '0;
        sb_new_reg  = '0;
        sb_warp_num = '0;
        if (active) begin
            if (grant) begin
                cand_ready[grant_warp] = 1'b1;
            end
            if (handshake && (issue_rd_q != '0)) begin
                sb_new_reg  = issue_rd_q;
                sb_warp_num = issue_warp_q;
            end
            case (state_q)
                ISSUE_EMPTY: begin
                    if (grant) begin
                        state_d = ISSUE_FULL;
                    end
                end
                ISSUE_FULL: begin
                    if (issue_ready && !grant) begin
                        state_d = ISSUE_EMPTY;
                    end
                end
                default: state_d = ISSUE_EMPTY;
            endcase
        end
    end

    // Issue-stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue payload and round-robin pointer.
    // Both load only on a grant.
    // The pointer moves just past the winner, so that warp has lowest
    // priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_warp_q <= '0;
            issue_rs1_q  <= '0;
            issue_rs2_q  <= '0;
            issue_rd_q   <= '0;
            rr_q         <= '0;
        end else if (grant) begin
            issue_warp_q <= grant_warp;
            issue_rs1_q  <= cand_rs1[grant_warp*REG_W +: REG_W];
            issue_rs2_q  <= cand_rs2[grant_warp*REG_W +: REG_W];
            issue_rd_q   <= cand_rd[grant_warp*REG_W +: REG_W];
            rr_q         <= (grant_warp == WIDX_W'(WARP_NUM - 1)) ? '0 : grant_warp + 1'b1;
        end
    end

    // Shadow of the last recorded destination.
    // Lives for exactly one active cycle, while the scoreboard write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_valid_q <= 1'b0;
            shadow_warp_q  <= '0;
            shadow_reg_q   <= '0;
        end else if (active) begin
            shadow_valid_q <= handshake && (issue_rd_q != '0);
            if (handshake && (issue_rd_q != '0)) begin
                shadow_warp_q <= issue_warp_q;
                shadow_reg_q  <= issue_rd_q;
            end
        end
    end

    // Stall counter.
    // Counts every enabled cycle in which some warp offers work but none is
    // granted, whether the cause is hazards or downstream backpressure.
    // The count saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (active && (|cand_valid) && !grant && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_gelato_warp_issue_arbiter.sv
// ============================================================================
// tb_gelato_warp_issue_arbiter
//
// Purpose:
//   Directed bench for gelato_warp_issue_arbiter.
//   Each step drives the inputs, lets them settle, and compares outputs
//   against hand-computed values.
//   Combinational outputs are sampled 2 ns after the clock edge.
//   Registered outputs are sampled 1 ns after the clock edge.
//
// Expected values:
//   Stall-count and writeback-timing expectations follow
//   GELATO_ISSUE_WB_BYPASS_EN when that macro is defined.
// ============================================================================
module tb_gelato_warp_issue_arbiter;

    localparam int WARP_NUM = 4;
    localparam int SB_SIZE  = 4;
    localparam int REG_W    = 5;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              rdy;
    logic [WARP_NUM-1:0]               cand_valid;
    logic [WARP_NUM*REG_W-1:0]         cand_rs1;
    logic [WARP_NUM*REG_W-1:0]         cand_rs2;
    logic [WARP_NUM*REG_W-1:0]         cand_rd;
    logic [WARP_NUM-1:0]               cand_ready;
    logic [WARP_NUM*SB_SIZE*REG_W-1:0] sb_regs;
    logic                              wb_valid;
    logic [1:0]                        wb_warp;
    logic [REG_W-1:0]                  wb_reg;
    logic                              issue_valid;
    logic                              issue_ready;
    logic [1:0]                        issue_warp;
    logic [REG_W-1:0]                  issue_rs1;
    logic [REG_W-1:0]                  issue_rs2;
    logic [REG_W-1:0]                  issue_rd;
    logic [REG_W-1:0]                  sb_new_reg;
    logic [1:0]                        sb_warp_num;
    logic [31:0]                       stall_cycles;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_stall;

    gelato_warp_issue_arbiter #(
        .WARP_NUM (WARP_NUM),
        .SB_SIZE  (SB_SIZE),
        .REG_W    (REG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .cand_valid   (cand_valid),
        .cand_rs1     (cand_rs1),
        .cand_rs2     (cand_rs2),
        .cand_rd      (cand_rd),
        .cand_ready   (cand_ready),
        .sb_regs      (sb_regs),
        .wb_valid     (wb_valid),
        .wb_warp      (wb_warp),
        .wb_reg       (wb_reg),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_warp   (issue_warp),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .sb_new_reg   (sb_new_reg),
        .sb_warp_num  (sb_warp_num),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input int w, input logic v, input logic [REG_W-1:0] rs1,
                                 input logic [REG_W-1:0] rs2, input logic [REG_W-1:0] rd);
        cand_valid[w]                = v;
        cand_rs1[w*REG_W +: REG_W]   = rs1;
        cand_rs2[w*REG_W +: REG_W]   = rs2;
        cand_rd[w*REG_W +: REG_W]    = rd;
    endtask

    task automatic clearCands();
        cand_valid = '0;
        cand_rs1   = '0;
        cand_rs2   = '0;
        cand_rd    = '0;
    endtask

    task automatic setSb(input int w, input int s, input logic [REG_W-1:0] val);
        sb_regs[(w*SB_SIZE + s)*REG_W +: REG_W] = val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    initial begin
        rst         = 1'b1;
        rdy         = 1'b1;
        issue_ready = 1'b1;
        wb_valid    = 1'b0;
        wb_warp     = '0;
        wb_reg      = '0;
        sb_regs     = '0;
        clearCands();
        tick();
        tick();

        // ---------------- reset state ----------------
        for (int w = 0; w < WARP_NUM; w++) begin
            applyStimulus(w, 1'b1, 5'd0, 5'd0, 5'(w + 1));
        end
        settle();
        checkOutput("rst_cand_ready", 32'(cand_ready), 32'h0);
        checkOutput("rst_issue_valid", 32'(issue_valid), 32'h0);
        checkOutput("rst_issue_rd", 32'(issue_rd), 32'h0);
        checkOutput("rst_sb_new_reg", 32'(sb_new_reg), 32'h0);
        checkOutput("rst_stall", stall_cycles, 32'h0);

        // ---------------- test 1: round robin w0..w3,w0 ----------------
        rst = 1'b0;
        settle();
        checkOutput("t1_grant_w0", 32'(cand_ready), 32'b0001);
        checkOutput("t1_no_record_empty", 32'(sb_new_reg), 32'h0);
        tick();
        checkOutput("t1_issue_valid", 32'(issue_valid), 32'h1);
        checkOutput("t1_issue_warp0", 32'(issue_warp), 32'h0);
        checkOutput("t1_issue_rd1", 32'(issue_rd), 32'h1);
        settle();
        checkOutput("t1_record1", 32'(sb_new_reg), 32'h1);
        checkOutput("t1_record1_warp", 32'(sb_warp_num), 32'h0);
        checkOutput("t1_grant_w1", 32'(cand_ready), 32'b0010);
        tick();
        checkOutput("t1_issue_warp1", 32'(issue_warp), 32'h1);
        settle();
        checkOutput("t1_record2", 32'(sb_new_reg), 32'h2);
        checkOutput("t1_grant_w2", 32'(cand_ready), 32'b0100);
        tick();
        checkOutput("t1_issue_warp2", 32'(issue_warp), 32'h2);
        settle();
        checkOutput("t1_record3", 32'(sb_new_reg), 32'h3);
        checkOutput("t1_record3_warp", 32'(sb_warp_num), 32'h2);
        checkOutput("t1_grant_w3", 32'(cand_ready), 32'b1000);
        tick();
        checkOutput("t1_issue_rd4", 32'(issue_rd), 32'h4);
        settle();
        checkOutput("t1_record4", 32'(sb_new_reg), 32'h4);
        checkOutput("t1_record4_warp", 32'(sb_warp_num), 32'h3);
        checkOutput("t1_grant_w0_wrap", 32'(cand_ready), 32'b0001);
        tick();
        checkOutput("t1_issue_warp0_again", 32'(issue_warp), 32'h0);
        clearCands();
        settle();
        checkOutput("t1_record1_again", 32'(sb_new_reg), 32'h1);
        checkOutput("t1_idle_no_grant", 32'(cand_ready), 32'h0);
        tick();
        checkOutput("t1_drain_empty", 32'(issue_valid), 32'h0);
        checkOutput("t1_stall_zero", stall_cycles, 32'h0);

        // ---------------- test 3: shadow blocks same-warp RAW ----------------
        applyStimulus(1, 1'b1, 5'd0, 5'd0, 5'd9);
        settle();
        checkOutput("t3_grant_w1", 32'(cand_ready), 32'b0010);
        tick();
        checkOutput("t3_issue_rd9", 32'(issue_rd), 32'h9);
        clearCands();
        settle();
        checkOutput("t3_record9", 32'(sb_new_reg), 32'h9);
        checkOutput("t3_record9_warp", 32'(sb_warp_num), 32'h1);
        tick();
        applyStimulus(1, 1'b1, 5'd0, 5'd9, 5'd0);
        settle();
        checkOutput("t3_shadow_block", 32'(cand_ready), 32'h0);
        tick();
        setSb(1, 0, 5'd9);
        settle();
        checkOutput("t3_sb_block", 32'(cand_ready), 32'h0);
        tick();
        checkOutput("t3_stall", stall_cycles, 32'h2);
        clearCands();
        sb_regs = '0;

        // ---------------- test 2: scoreboard hazard and writeback ----------------
        setSb(2, 0, 5'd7);
        applyStimulus(2, 1'b1, 5'd7, 5'd0, 5'd0);
        applyStimulus(3, 1'b1, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("t2_skip_w2", 32'(cand_ready), 32'b1000);
        tick();
        checkOutput("t2_issue_w3", 32'(issue_warp), 32'h3);
        applyStimulus(3, 1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("t2_w2_blocked", 32'(cand_ready), 32'h0);
        tick();
        wb_valid = 1'b1;
        wb_warp  = 2'd2;
        wb_reg   = 5'd7;
        settle();
`ifdef GELATO_ISSUE_WB_BYPASS_EN
        checkOutput("t2_wb_bypass_grant", 32'(cand_ready), 32'b0100);
        tick();
        exp_stall = 32'd3;
`else
        checkOutput("t2_wb_cycle_blocked", 32'(cand_ready), 32'h0);
        tick();
        wb_valid = 1'b0;
        sb_regs  = '0;
        settle();
        checkOutput("t2_grant_after_wb", 32'(cand_ready), 32'b0100);
        tick();
        exp_stall = 32'd4;
`endif
        clearCands();
        wb_valid = 1'b0;
        sb_regs  = '0;
        checkOutput("t2_issue_w2", 32'(issue_warp), 32'h2);
        checkOutput("t2_issue_rs1", 32'(issue_rs1), 32'h7);
        checkOutput("t2_stall", stall_cycles, exp_stall);

        // ---------------- test 4: backpressure for 5 cycles ----------------
        issue_ready = 1'b0;
        applyStimulus(0, 1'b1, 5'd0, 5'd0, 5'd5);
        for (int c = 0; c < 5; c++) begin
            settle();
            checkOutput("t4_bp_cand_ready", 32'(cand_ready), 32'h0);
            checkOutput("t4_bp_issue_warp", 32'(issue_warp), 32'h2);
            checkOutput("t4_bp_issue_rs1", 32'(issue_rs1), 32'h7);
            checkOutput("t4_bp_issue_valid", 32'(issue_valid), 32'h1);
            tick();
        end
        exp_stall = exp_stall + 32'd5;
        checkOutput("t4_stall_plus5", stall_cycles, exp_stall);
        issue_ready = 1'b1;
        settle();
        checkOutput("t4_release_grant", 32'(cand_ready), 32'b0001);
        tick();
        checkOutput("t4_backtoback_valid", 32'(issue_valid), 32'h1);
        checkOutput("t4_backtoback_warp", 32'(issue_warp), 32'h0);
        checkOutput("t4_backtoback_rd", 32'(issue_rd), 32'h5);

        // ---------------- test 5: full scoreboard row ----------------
        clearCands();
        applyStimulus(0, 1'b1, 5'd0, 5'd0, 5'd3);
        setSb(0, 0, 5'd11);
        setSb(0, 1, 5'd12);
        setSb(0, 2, 5'd13);
        setSb(0, 3, 5'd14);
        settle();
        checkOutput("t5_full_row_block", 32'(cand_ready), 32'h0);
        checkOutput("t5_record5", 32'(sb_new_reg), 32'h5);
        checkOutput("t5_record5_warp", 32'(sb_warp_num), 32'h0);
        tick();
        exp_stall = exp_stall + 32'd1;
        applyStimulus(0, 1'b1, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("t5_rd0_grant", 32'(cand_ready), 32'b0001);
        tick();
        checkOutput("t5_issue_rd0", 32'(issue_rd), 32'h0);
        clearCands();
        sb_regs = '0;
        settle();
        checkOutput("t5_no_record_rd0", 32'(sb_new_reg), 32'h0);
        checkOutput("t5_stall", stall_cycles, exp_stall);
        tick();

        // ---------------- test 6: rdy freeze, then reset ----------------
        applyStimulus(1, 1'b1, 5'd0, 5'd0, 5'd6);
        applyStimulus(2, 1'b1, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("t6_grant_w1", 32'(cand_ready), 32'b0010);
        tick();
        rdy = 1'b0;
        settle();
        checkOutput("t6_frozen_cand_ready", 32'(cand_ready), 32'h0);
        checkOutput("t6_frozen_sb_new_reg", 32'(sb_new_reg), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("t6_frozen_issue_warp", 32'(issue_warp), 32'h1);
            checkOutput("t6_frozen_issue_rd", 32'(issue_rd), 32'h6);
            checkOutput("t6_frozen_valid", 32'(issue_valid), 32'h1);
            checkOutput("t6_frozen_stall", stall_cycles, exp_stall);
        end
        rdy = 1'b1;
        settle();
        checkOutput("t6_resume_grant_w2", 32'(cand_ready), 32'b0100);
        checkOutput("t6_resume_record6", 32'(sb_new_reg), 32'h6);
        checkOutput("t6_resume_record_warp", 32'(sb_warp_num), 32'h1);
        tick();
        checkOutput("t6_issue_w2", 32'(issue_warp), 32'h2);
        issue_ready = 1'b0;
        rst         = 1'b1;
        settle();
        checkOutput("t6_rst_cand_ready", 32'(cand_ready), 32'h0);
        tick();
        checkOutput("t6_rst_issue_valid", 32'(issue_valid), 32'h0);
        checkOutput("t6_rst_issue_warp", 32'(issue_warp), 32'h0);
        checkOutput("t6_rst_stall", stall_cycles, 32'h0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
